// File: rtl/config_pkg.sv
// Shared configuration of the ternary matmul AFU: sizes, DDR word/address
// types, the instruction format and the fixed program run on each start.
package config_pkg;

  localparam int D               = 8;
  localparam int DataWidth       = 16;
  localparam int NumInstructions = 4;

  localparam int AddrWidth = $clog2(D * D);
  localparam int RowWidth  = $clog2(D);
  localparam int PcWidth   = (NumInstructions > 1) ? $clog2(NumInstructions) : 1;

  typedef logic [DataWidth-1:0]        ddr_data_t;
  typedef logic [AddrWidth-1:0]        ddr_address_t;
  typedef logic [RowWidth-1:0]         row_t;
  typedef logic [PcWidth-1:0]          pc_t;
  typedef logic [D-1:0][DataWidth-1:0] vec_t;

  typedef enum logic [1:0] {
    OP_NOP    = 2'd0,
    OP_LOADX  = 2'd1,
    OP_MATVEC = 2'd2,
    OP_STORE  = 2'd3
  } opcode_t;

  typedef struct packed {
    opcode_t op;
    row_t    row;
  } instr_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_RD_REQ  = 3'd2,
    ST_RD_WAIT = 3'd3,
    ST_WR_REQ  = 3'd4,
    ST_WR_WAIT = 3'd5,
    ST_NEXT    = 3'd6
  } state_t;

  // Load X from row 0, multiply by the W matrix whose rows start at row 1,
  // store Y into row 2, then one idle slot.
  localparam instr_t Program [NumInstructions] = '{
    '{OP_LOADX,  row_t'(0)},
    '{OP_MATVEC, row_t'(1)},
    '{OP_STORE,  row_t'(2)},
    '{OP_NOP,    row_t'(0)}
  };

  // Word address of element idx within DDR row `row`.
  function automatic ddr_address_t row_addr(input row_t row, input row_t idx);
    return ddr_address_t'(row) * ddr_address_t'(D) + ddr_address_t'(idx);
  endfunction

endpackage

// File: rtl/ternary_dot.sv
// Combinational signed dot product of one packed ternary row with vector X.
// Each element j uses the 2-bit code row[2j+1:2j]: 01 -> +X[j], 11 -> -X[j],
// 00/10 -> 0. The sum wraps modulo 2^DataWidth.
module ternary_dot
  import config_pkg::*;
(
  input  ddr_data_t row_i,
  input  vec_t      x_i,
  output ddr_data_t dot_o
);

  vec_t      term;
  ddr_data_t acc;

  for (genvar gi = 0; gi < D; gi++) begin : g_term
    logic [1:0] code;
    assign code = row_i[2*gi+1 -: 2];
    assign term[gi] = (code == 2'b01) ? x_i[gi] :
                      (code == 2'b11) ? (ddr_data_t'(0) - x_i[gi]) :
                                        ddr_data_t'(0);
  end

  // Accumulate all D terms; overflow simply wraps.
  always_comb begin
    acc = '0;
    for (int j = 0; j < D; j++) begin
      acc = acc + term[j];
    end
  end

  assign dot_o = acc;

endmodule

// File: rtl/matrix_unit.sv
// Sequencer/datapath of the ternary matmul AFU. On start it walks the fixed
// program, moving D-word rows between DDR and the X/Y register files and
// computing Y = W*X one DDR row of W at a time. DDR is driven through a
// single-outstanding request port with one-cycle enable pulses.
module matrix_unit
  import config_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         start_i,
  output logic         ready_o,
  output ddr_address_t ddr_address_o,
  output logic         ddr_r_en_o,
  input  ddr_data_t    ddr_r_data_i,
  input  logic         ddr_r_valid_i,
  output logic         ddr_w_en_o,
  output ddr_data_t    ddr_w_data_o,
  input  logic         ddr_w_done_i
);

  state_t       state_q;
  pc_t          pc_q;
  row_t         idx_q;
  opcode_t      op_q;
  row_t         row_q;
  vec_t         x_q;
  vec_t         y_q;
  logic         ready_q;
  logic         r_en_q;
  logic         w_en_q;
  ddr_address_t addr_q;
  ddr_data_t    wdata_q;

  instr_t       instr;
  row_t         idx_next;
  logic         last_idx;
  logic         last_pc;
  ddr_data_t    dot;

  assign instr    = Program[pc_q];
  assign idx_next = idx_q + row_t'(1);
  assign last_idx = (idx_q == row_t'(D - 1));
  assign last_pc  = (pc_q == pc_t'(NumInstructions - 1));

  // The dot product is formed straight from the incoming W row so that Y[i]
  // can be written in the same cycle the read data is valid.
  ternary_dot u_dot (
    .row_i (ddr_r_data_i),
    .x_i   (x_q),
    .dot_o (dot)
  );

  // Program sequencer, element loop, X/Y register files and DDR port
  // registers. Enables default low every cycle so they can only ever be
  // single-cycle pulses; address and write data are only changed when a new
  // request is launched, which keeps them stable while a request is open.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      idx_q   <= '0;
      op_q    <= OP_NOP;
      row_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      ready_q <= 1'b1;
      r_en_q  <= 1'b0;
      w_en_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      r_en_q <= 1'b0;
      w_en_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // Stray DDR responses here are deliberately ignored.
          if (start_i) begin
            pc_q    <= '0;
            ready_q <= 1'b0;
            state_q <= ST_FETCH;
          end
        end

        ST_FETCH: begin
          op_q   <= instr.op;
          row_q  <= instr.row;
          idx_q  <= '0;
          addr_q <= row_addr(instr.row, row_t'(0));
          case (instr.op)
            OP_LOADX, OP_MATVEC: begin
              r_en_q  <= 1'b1;
              state_q <= ST_RD_REQ;
            end
            OP_STORE: begin
              w_en_q  <= 1'b1;
              wdata_q <= y_q[0];
              state_q <= ST_WR_REQ;
            end
            default: state_q <= ST_NEXT;
          endcase
        end

        // The enable pulse is on the port during this cycle.
        ST_RD_REQ: state_q <= ST_RD_WAIT;

        ST_RD_WAIT: begin
          if (ddr_r_valid_i) begin
            if (op_q == OP_LOADX) begin
              x_q[idx_q] <= ddr_r_data_i;
            end else begin
              y_q[idx_q] <= dot;
            end
            if (last_idx) begin
              state_q <= ST_NEXT;
            end else begin
              // Launch the next read right away to keep the port busy.
              idx_q   <= idx_next;
              addr_q  <= row_addr(row_q, idx_next);
              r_en_q  <= 1'b1;
              state_q <= ST_RD_REQ;
            end
          end
        end

        ST_WR_REQ: state_q <= ST_WR_WAIT;

        ST_WR_WAIT: begin
          if (ddr_w_done_i) begin
            if (last_idx) begin
              state_q <= ST_NEXT;
            end else begin
              idx_q   <= idx_next;
              addr_q  <= row_addr(row_q, idx_next);
              wdata_q <= y_q[idx_next];
              w_en_q  <= 1'b1;
              state_q <= ST_WR_REQ;
            end
          end
        end

        ST_NEXT: begin
          if (last_pc) begin
            ready_q <= 1'b1;
            state_q <= ST_IDLE;
          end else begin
            pc_q    <= pc_q + pc_t'(1);
            state_q <= ST_FETCH;
          end
        end

        default: begin
          ready_q <= 1'b1;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign ready_o       = ready_q;
  assign ddr_address_o = addr_q;
  assign ddr_r_en_o    = r_en_q;
  assign ddr_w_en_o    = w_en_q;
  assign ddr_w_data_o  = wdata_q;

endmodule

// File: tb/tb_matrix_unit.sv
// Directed bench for matrix_unit: a DDR model with programmable latency,
// protocol monitoring and hand-computed result vectors.
module tb_matrix_unit;
  import config_pkg::*;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         ready;
  ddr_address_t addr;
  logic         r_en;
  ddr_data_t    r_data = '0;
  logic         r_valid = 1'b0;
  logic         w_en;
  ddr_data_t    w_data;
  logic         w_done = 1'b0;

  matrix_unit dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .start_i       (start),
    .ready_o       (ready),
    .ddr_address_o (addr),
    .ddr_r_en_o    (r_en),
    .ddr_r_data_i  (r_data),
    .ddr_r_valid_i (r_valid),
    .ddr_w_en_o    (w_en),
    .ddr_w_data_o  (w_data),
    .ddr_w_done_i  (w_done)
  );

  always #5 clk = ~clk;

  // DDR model state. mem is written only by the stimulus; writes from the
  // DUT land in wmem tagged with the current generation number.
  logic [15:0] mem  [64];
  logic [15:0] wmem [64];
  int          wgen [64];
  int          gen = 0;
  int          lat = 2;
  logic        rd_pend = 1'b0;
  logic        wr_pend = 1'b0;
  int          cnt = 0;
  logic [5:0]  paddr = '0;
  logic [15:0] pdata = '0;
  int          proto_err = 0;
  int          rd_cnt = 0;
  int          wr_cnt = 0;

  int checks = 0;
  int errors = 0;

  logic [15:0] xv [8];
  logic [15:0] wv [8];
  logic [15:0] yv [8];

  always @(posedge clk) begin
    r_valid <= 1'b0;
    w_done  <= 1'b0;
    if (r_en === 1'b1) rd_cnt++;
    if (w_en === 1'b1) wr_cnt++;
    if (rst) begin
      rd_pend <= 1'b0;
      wr_pend <= 1'b0;
    end else begin
      if (r_en === 1'b1 && w_en === 1'b1) proto_err++;
      if (rd_pend || wr_pend) begin
        if (addr !== paddr) proto_err++;
        if (wr_pend && w_data !== pdata) proto_err++;
        if (cnt <= 1) begin
          if (rd_pend) begin
            r_valid <= 1'b1;
            r_data  <= mem[paddr];
          end else begin
            w_done      <= 1'b1;
            wmem[paddr] <= pdata;
            wgen[paddr] <= gen;
          end
          rd_pend <= 1'b0;
          wr_pend <= 1'b0;
        end else begin
          cnt <= cnt - 1;
        end
      end
      if (r_en === 1'b1 || w_en === 1'b1) begin
        if (rd_pend || wr_pend) proto_err++;
        rd_pend <= (r_en === 1'b1);
        wr_pend <= (r_en !== 1'b1);
        paddr   <= addr;
        pdata   <= w_data;
        cnt     <= lat - 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Place X in row 0 and W in row 1, open a new write generation.
  task automatic prep();
    for (int i = 0; i < 8; i++) begin
      mem[i]     = xv[i];
      mem[8 + i] = wv[i];
    end
    gen++;
  endtask

  // Start the program, optionally poke start again mid-run, wait for ready
  // within budget cycles, then check results and request counts.
  task automatic run_and_verify(input string tag, input int budget, input int poke_at);
    int n;
    int rd0;
    int wr0;
    int perr0;
    rd0   = rd_cnt;
    wr0   = wr_cnt;
    perr0 = proto_err;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check({tag, " busy"}, 32'(ready), 32'd0);
    n = 0;
    while (ready !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
      start = (n == poke_at) ? 1'b1 : 1'b0;
    end
    start = 1'b0;
    check({tag, " ready within budget"}, 32'(ready), 32'd1);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("%s y%0d written", tag, i), 32'(wgen[16 + i] == gen), 32'd1);
      check($sformatf("%s y%0d", tag, i), 32'(wmem[16 + i]), 32'(yv[i]));
    end
    check({tag, " reads"}, 32'(rd_cnt - rd0), 32'd16);
    check({tag, " writes"}, 32'(wr_cnt - wr0), 32'd8);
    check({tag, " protocol"}, 32'(proto_err - perr0), 32'd0);
    $display("run %s: %0d cycles", tag, n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int en0;

    // Reset held.
    repeat (3) @(negedge clk);
    check("reset ready", 32'(ready), 32'd1);
    check("reset r_en", 32'(r_en), 32'd0);
    check("reset w_en", 32'(w_en), 32'd0);
    check("reset addr", 32'(addr), 32'd0);
    check("reset wdata", 32'(w_data), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Identity W, X = 1..8.
    xv = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8};
    wv = '{16'h0001, 16'h0004, 16'h0010, 16'h0040, 16'h0100, 16'h0400, 16'h1000, 16'h4000};
    yv = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8};
    prep();
    run_and_verify("identity", D * D * NumInstructions, 0);

    // All -1 rows: each Y = -(1+..+8) = -36.
    wv = '{default: 16'hFFFF};
    yv = '{default: 16'hFFDC};
    prep();
    run_and_verify("neg", D * D * NumInstructions, 0);

    // Mixed codes including 2'b10, X = 7FFF: sums wrap.
    xv = '{default: 16'h7FFF};
    wv = '{16'h5555, 16'hAAAA, 16'hFFFF, 16'h0005, 16'h000D, 16'h0001, 16'h0015, 16'h0009};
    yv = '{16'hFFF8, 16'h0000, 16'h0008, 16'hFFFE, 16'h0000, 16'h7FFF, 16'h7FFD, 16'h7FFF};
    prep();
    run_and_verify("wrap", D * D * NumInstructions, 0);

    // 10-cycle responses plus a start pulse mid-run.
    lat = 10;
    xv = '{16'd10, 16'd20, 16'd30, 16'd40, 16'd50, 16'd60, 16'd70, 16'd80};
    wv = '{16'h0001, 16'h0004, 16'h0010, 16'h0040, 16'h0100, 16'h0400, 16'h1000, 16'h4000};
    yv = '{16'd10, 16'd20, 16'd30, 16'd40, 16'd50, 16'd60, 16'd70, 16'd80};
    prep();
    run_and_verify("slow", 2000, 40);
    lat = 2;

    // Reset while the MATVEC reads are in flight.
    xv = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8};
    prep();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    n = 0;
    while (!(r_en === 1'b1 && addr >= 6'd8) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("matvec reached", 32'(n < 200), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    en0 = rd_cnt + wr_cnt;
    #1;
    check("abort ready", 32'(ready), 32'd1);
    check("abort r_en", 32'(r_en), 32'd0);
    check("abort w_en", 32'(w_en), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("abort no enables", 32'(rd_cnt + wr_cnt - en0), 32'd0);
    check("abort still idle", 32'(ready), 32'd1);
    check("abort no store", 32'(wgen[16] == gen), 32'd0);

    // Clean rerun after the abort.
    xv = '{16'd3, 16'd1, 16'd4, 16'd1, 16'd5, 16'd9, 16'd2, 16'd6};
    yv = '{16'd3, 16'd1, 16'd4, 16'd1, 16'd5, 16'd9, 16'd2, 16'd6};
    prep();
    run_and_verify("rerun", D * D * NumInstructions, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
